// File: rtl/if_id_stage.sv
// IF/ID pipeline register: stall/flush control, valid and delay-slot tracking, predecode, stall watchdog.
// Optional perf counters (stall_cycles, flush_count) are built only when IF_ID_PERF_EN is defined.
module if_id_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
  parameter int unsigned STALL_CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] Instruction_F,
  input  logic [31:0] PC_plus_4_F,
  input  logic [31:0] PC_plus_8_F,
  output logic [31:0] Instruction_D,
  output logic [31:0] PC_plus_4_D,
  output logic [31:0] PC_plus_8_D,
  output logic [31:0] PC_D,
  output logic        valid_D,
  output logic        in_delay_slot_D,
  output logic [4:0]  rs_D,
  output logic [4:0]  rt_D,
  output logic [4:0]  rd_D,
  output logic [15:0] imm16_D,
  output logic        is_branch_D,
  output logic        is_jump_D,
  output logic        is_jr_D,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  logic [31:0]            instr_q, instr_d;
  logic [31:0]            pc4_q, pc4_d;
  logic [31:0]            pc8_q, pc8_d;
  logic                   valid_q, valid_d;
  logic                   ds_q, ds_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr_q[31:26];
  assign funct  = instr_q[5:0];

  // Flags are gated by valid so a bubble never looks like control flow.
  always_comb begin
    is_branch_D = 1'b0;
    is_jump_D   = 1'b0;
    is_jr_D     = 1'b0;
    if (valid_q) begin
      is_branch_D = (opcode == 6'b000001) || (opcode == 6'b000100) ||
                    (opcode == 6'b000101) || (opcode == 6'b000110) ||
                    (opcode == 6'b000111);
      is_jump_D   = (opcode == 6'b000010) || (opcode == 6'b000011);
      is_jr_D     = (opcode == 6'b000000) &&
                    ((funct == 6'b001000) || (funct == 6'b001001));
    end
  end

  always_comb begin
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    pc8_d       = pc8_q;
    valid_d     = valid_q;
    ds_d        = ds_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      instr_d     = NOP_INSTR;
      valid_d     = 1'b0;
      ds_d        = 1'b0;
      stall_cnt_d = '0;
    end else if (!en) begin
      if (valid_q && !(&stall_cnt_q))
        stall_cnt_d = stall_cnt_q + 1'b1;
    end else begin
      instr_d     = Instruction_F;
      pc4_d       = PC_plus_4_F;
      pc8_d       = PC_plus_8_F;
      valid_d     = 1'b1;
      ds_d        = is_branch_D | is_jump_D | is_jr_D;
      stall_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q     <= NOP_INSTR;
      pc4_q       <= RESET_PC + 32'd4;
      pc8_q       <= RESET_PC + 32'd8;
      valid_q     <= 1'b0;
      ds_q        <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      pc8_q       <= pc8_d;
      valid_q     <= valid_d;
      ds_q        <= ds_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (flush) begin
      if (!(&flush_count_q)) flush_count_d = flush_count_q + 32'd1;
    end else if (!en) begin
      if (!(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

  assign Instruction_D   = instr_q;
  assign PC_plus_4_D     = pc4_q;
  assign PC_plus_8_D     = pc8_q;
  assign PC_D            = pc4_q - 32'd4;
  assign valid_D         = valid_q;
  assign in_delay_slot_D = ds_q;
  assign rs_D            = instr_q[25:21];
  assign rt_D            = instr_q[20:16];
  assign rd_D            = instr_q[15:11];
  assign imm16_D         = instr_q[15:0];
  assign stall_timeout   = &stall_cnt_q;

endmodule
